// File: rtl/sram_pkg.sv
// Shared types for the two-port SRAM controller: FSM state encoding and port index.
package sram_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } sram_state_t;

  typedef logic port_idx_t;

  localparam int NUM_PORTS = 2;

  function automatic port_idx_t onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    return port_idx_t'(oh == 2'b10);
  endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Two-requester round-robin arbiter; the pointer advances only when a grant is taken.
module sram_rr_arb
  import sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  port_idx_t last_q;

  // last_q resets to port 1 so that port 0 wins the first contended cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= onehot_to_idx(grant);
    end
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_q == 1'b1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_ctrl.sv
// Two-port request front end for a single-port SRAM cell array: one access per two cycles.
// Build option SRAM_CTRL_INIT_EN: zero every row out of reset before requests are accepted.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter  int ROWS = 64,
  parameter  int COLS = 64,
  localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p0_valid,
  output logic            p0_ready,
  input  logic            p0_we,
  input  logic [AW-1:0]   p0_addr,
  input  logic [COLS-1:0] p0_wdata,
  input  logic [COLS-1:0] p0_wmask,
  output logic            p0_rvalid,
  output logic [COLS-1:0] p0_rdata,
  input  logic            p1_valid,
  output logic            p1_ready,
  input  logic            p1_we,
  input  logic [AW-1:0]   p1_addr,
  input  logic [COLS-1:0] p1_wdata,
  input  logic [COLS-1:0] p1_wmask,
  output logic            p1_rvalid,
  output logic [COLS-1:0] p1_rdata,
  output logic [AW-1:0]   arr_row_select,
  output logic [COLS-1:0] arr_col_write_enable,
  output logic [COLS-1:0] arr_col_data_in,
  input  logic [COLS-1:0] arr_col_data_out,
  output logic            init_done
);

`ifdef SRAM_CTRL_INIT_EN
  localparam sram_state_t RST_STATE = INIT;
`else
  localparam sram_state_t RST_STATE = IDLE;
`endif

  sram_state_t     state, state_nx;
  logic [1:0]      req, grant, ready;
  logic            accept;
  port_idx_t       gnt_idx, port_q, rd_port;
  logic            rd_pend;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [COLS-1:0] sel_wdata, sel_wmask;
  logic [AW-1:0]   row_q;
  logic [COLS-1:0] wen_q, din_q;

  assign req      = {p1_valid, p0_valid};
  assign ready    = (state == IDLE && init_done) ? grant : 2'b00;
  assign p0_ready = ready[0];
  assign p1_ready = ready[1];
  assign accept   = |(req & ready);
  assign gnt_idx  = onehot_to_idx(grant);

  assign sel_we    = (gnt_idx == 1'b1) ? p1_we    : p0_we;
  assign sel_addr  = (gnt_idx == 1'b1) ? p1_addr  : p0_addr;
  assign sel_wdata = (gnt_idx == 1'b1) ? p1_wdata : p0_wdata;
  assign sel_wmask = (gnt_idx == 1'b1) ? p1_wmask : p0_wmask;

  sram_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

`ifdef SRAM_CTRL_INIT_EN
  logic [AW-1:0] init_row;
  logic          init_last;

  assign init_last = (init_row == AW'(ROWS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_row <= '0;
    end else if (state == INIT) begin
      init_row <= init_row + 1'b1;
    end
  end

  // INIT drives the array straight from the row counter so row 0 is written in the
  // release cycle and row ROWS-1 in the last INIT cycle; rst gates the enables
  // so nothing is written while reset is held.
  assign arr_row_select       = (state == INIT) ? init_row : row_q;
  assign arr_col_write_enable = (state == INIT) ? {COLS{rst}} : wen_q;
  assign arr_col_data_in      = (state == INIT) ? '0 : din_q;
`else
  assign arr_row_select       = row_q;
  assign arr_col_write_enable = wen_q;
  assign arr_col_data_in      = din_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RST_STATE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
`ifdef SRAM_CTRL_INIT_EN
      INIT:    if (init_last) state_nx = IDLE;
`endif
      IDLE:    if (accept) state_nx = sel_we ? WRITE : READ;
      WRITE:   state_nx = IDLE;
      READ:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request fields are captured straight into the array-facing registers at acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q  <= '0;
      wen_q  <= '0;
      din_q  <= '0;
      port_q <= 1'b0;
    end else begin
      wen_q <= '0;
      if (accept) begin
        port_q <= gnt_idx;
        row_q  <= sel_addr;
        if (sel_we) begin
          wen_q <= sel_wmask;
          din_q <= sel_wdata;
        end
      end
    end
  end

  // Read data lands at the end of READ; the strobe follows one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend   <= 1'b0;
      rd_port   <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      rd_pend   <= (state == READ);
      p0_rvalid <= rd_pend && (rd_port == 1'b0);
      p1_rvalid <= rd_pend && (rd_port == 1'b1);
      if (state == READ) begin
        rd_port <= port_q;
        if (port_q == 1'b1) begin
          p1_rdata <= arr_col_data_out;
        end else begin
          p0_rdata <= arr_col_data_out;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_done <= 1'b0;
`ifdef SRAM_CTRL_INIT_EN
    end else if (state == INIT && init_last) begin
      init_done <= 1'b1;
`else
    end else begin
      init_done <= 1'b1;
`endif
    end
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 64, number of array rows.
REQ-002 SHALL have parameter COLS, default 64, bits per row (word width).
REQ-003 SHALL have ports, in order:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pN_valid  input  1  request valid, N in {0,1}.
- pN_ready  output  1  request accepted when valid and ready are both high.
- pN_we  input  1  1 = write, 0 = read.
- pN_addr  input  $clog2(ROWS)  row address.
- pN_wdata  input  COLS  write data.
- pN_wmask  input  COLS  per-bit write enable.
- pN_rvalid  output  1  one-cycle read-data strobe.
- pN_rdata  output  COLS  read data.
- arr_row_select  output  $clog2(ROWS)  array row select.
- arr_col_write_enable  output  COLS  array column write enables.
- arr_col_data_in  output  COLS  array write data.
- arr_col_data_out  input  COLS  array read data for the selected row, combinational.
- init_done  output  1  high once the controller accepts requests.

Function
REQ-004 SHALL implement the FSM states INIT, IDLE, WRITE and READ; leaving reset, the FSM enters INIT when SRAM_CTRL_INIT_EN is defined and IDLE otherwise.
REQ-005 SHALL raise at most one pN_ready in a cycle, and only in IDLE.
REQ-006 SHALL arbitrate round-robin in IDLE: a lone valid wins; when both are valid, the port not granted last wins; after reset, port 0 has priority.
REQ-007 SHALL register addr, we, wdata, wmask and the granted port index at acceptance.
REQ-008 SHALL, in WRITE (one cycle), drive arr_row_select=addr, arr_col_write_enable=wmask, arr_col_data_in=wdata, then return to IDLE; an all-zero mask completes with no cell change.
REQ-009 SHALL, in READ (one cycle), drive arr_row_select=addr with arr_col_write_enable=0, capture arr_col_data_out into the granted port's pN_rdata at that cycle's end, pulse pN_rvalid for one cycle, and return to IDLE.
REQ-010 SHALL deliver read data with latency exactly 2 cycles: handshake at edge E, rvalid high in the cycle after edge E+2; throughput is one access per 2 cycles.
REQ-011 SHALL hold pN_rdata stable between strobes; the other port's rdata/rvalid SHALL be unaffected.
REQ-012 SHALL drive arr_col_write_enable to 0 in every state except WRITE and INIT.
REQ-013 SHALL ignore pN_we/addr/wdata changes while pN_ready is low; valid MAY drop without handshake.
REQ-014 SHALL make a read of a row written by the immediately preceding access return the new data; no bypass is needed because the write commits before READ.

Reset
REQ-015 SHALL, while rst=0, force: state per REQ-004, pN_ready=0, pN_rvalid=0, pN_rdata=0, arr_row_select=0, arr_col_write_enable=0, arr_col_data_in=0, init_done=0, round-robin pointer = port 0.
REQ-016 SHALL abort any in-flight access when reset asserts mid-operation; no rvalid is issued for it.

Configuration
REQ-017 SHALL, with SRAM_CTRL_INIT_EN defined, use INIT as a row counter 0..ROWS-1 that writes all-zero data with all column enables set, one row per cycle, then enter IDLE with init_done=1 after ROWS cycles; pN_ready stays 0 throughout INIT.
REQ-018 SHALL, without SRAM_CTRL_INIT_EN, omit INIT and the row counter, and drive init_done=1 from the first cycle after reset release.

Structure
REQ-019 SHALL take the state enum type (sram_state_t) and the port-index type from package sram_pkg.
REQ-020 SHALL place the round-robin logic in sub-module sram_rr_arb (2 requesters: req, grant, last-grant update on accept).
REQ-021 SHALL connect directly to the cell array with no extra pipeline stage.

Verification
REQ-022 SHALL cover: p0 write addr=5, wdata=0xA5A5..., mask=all-1 -> arr_col_write_enable=all-1 with row_select=5 for 1 cycle, then a p0 read addr=5 -> p0_rvalid 2 cycles after handshake, p0_rdata=0xA5A5....
REQ-023 SHALL cover: p0 and p1 valid continuously -> grants alternate 0,1,0,1, one grant every 2 cycles.
REQ-024 SHALL cover: masked write addr=3, mask=0x0F, data=all-1 over a zeroed row -> a read returns 0x...0F.
REQ-025 SHALL cover, with SRAM_CTRL_INIT_EN: ROWS=64 -> init_done rises exactly 64 cycles after reset release, and a read of row 63 returns 0.
REQ-026 SHALL cover: reset asserted during READ -> no rvalid, all outputs at REQ-015 values, and a new request is accepted normally after reset release.
